// File: rtl/cla_nibble_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one 4-bit lookahead slice per clock.
// Each slice adds a + ~b with carry-in = ~borrow, the same structure as the 4-bit lookahead adder.
`timescale 1ns/1ps
module cla_nibble_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [CW+1:0]    base;
  logic [3:0]       a_k;
  logic [3:0]       b_k;
  logic [3:0]       g;
  logic [3:0]       p;
  logic [3:0]       c;
  logic             c4;
  logic [3:0]       slice_diff;
  logic             last_slice;
  logic             accept;

  assign base = {cnt, 2'b00};
  assign a_k  = a_reg[base +: 4];
  assign b_k  = b_reg[base +: 4];
  assign g    = a_k & ~b_k;
  assign p    = a_k ^ ~b_k;

  // Carry into the slice is the inverse of the borrow left by the previous slice.
  assign c[0] = ~borrow;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign slice_diff = p ^ c;
  assign last_slice = (cnt == CW'(N - 1));
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Overflow uses the freshly computed top slice since diff's MSB is written on this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_reg  <= a;
      b_reg  <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      diff[base +: 4] <= slice_diff;
      borrow          <= ~c4;
      cnt             <= cnt + CW'(1);
      if (last_slice) begin
        bout <= ~c4;
        ovf  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (slice_diff[3] != a_reg[WIDTH-1]);
      end
    end
  end

endmodule
